counter_read_master: RTL and testbench

//  Bus-side read engine for the 64-bit atomic event counter. One rd_start_i

---
 rtl/counter_read_master.sv | 106 ++++++++++
 tb/tb_counter_read_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_read_master.sv
// Two-request read engine for the 64-bit atomic event counter: lower word (atomic) then upper word.
// Optional COUNTER_READ_DELTA_EN adds delta_o = new snapshot - previous snapshot.
module counter_read_master #(
    parameter int ACK_TIMEOUT = 4,
    parameter int TMR_W       = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd_start_i,
    output logic        busy_o,
    output logic        req_o,
    output logic        atomic_o,
    input  logic        ack_i,
    input  logic [31:0] count_i,
    output logic [63:0] data_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [63:0] delta_o
);

    typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI, WAIT} state_t;

    state_t             state_q, state_d;
    logic               pending_q;
    logic [1:0]         ack_cnt_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [31:0]        lo_q;
    logic [63:0]        data_q;
    logic               valid_q, err_q;
    logic               ack_en, lo_ack, hi_ack, timeout;

    // Acks only count once both requests are on their way out.
    assign ack_en  = (state_q == REQ_HI) || (state_q == WAIT);
    assign lo_ack  = ack_en && ack_i && (ack_cnt_q == 2'd0);
    assign hi_ack  = ack_en && ack_i && (ack_cnt_q == 2'd1);
    assign timeout = (state_q == WAIT) && !hi_ack && (tmr_q == TMR_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (rd_start_i || pending_q) state_d = REQ_LO;
            REQ_LO: state_d = REQ_HI;
            REQ_HI: state_d = WAIT;
            WAIT:   if (hi_ack || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            ack_cnt_q <= 2'd0;
            tmr_q     <= '0;
            lo_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= hi_ack;
            err_q   <= timeout;
            // Single pending slot: any number of starts while busy collapse into one.
            if (state_q == IDLE)
                pending_q <= 1'b0;
            else if (rd_start_i)
                pending_q <= 1'b1;
            if (state_q == IDLE)
                ack_cnt_q <= 2'd0;
            else if (ack_en && ack_i)
                ack_cnt_q <= ack_cnt_q + 2'd1;
            if (state_q == REQ_LO)
                tmr_q <= '0;
            else if (state_q == WAIT)
                tmr_q <= tmr_q + TMR_W'(1);
            if (lo_ack)
                lo_q <= count_i;
            if (hi_ack)
                data_q <= {count_i, lo_q};
        end
    end

`ifdef COUNTER_READ_DELTA_EN
    logic [63:0] delta_q;

    // data_q still holds the previous snapshot when the new one lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            delta_q <= '0;
        else if (hi_ack)
            delta_q <= {count_i, lo_q} - data_q;
    end

    assign delta_o = delta_q;
`else
    assign delta_o = 64'h0;
`endif

    assign busy_o   = (state_q != IDLE);
    assign req_o    = (state_q == REQ_LO) || (state_q == REQ_HI);
    assign atomic_o = (state_q == REQ_LO);
    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_counter_read_master.sv
// Directed bench for counter_read_master with a behavioural counter that latches
// the upper word on atomic requests and acks one cycle after each request.
module tb_counter_read_master;

    logic        clk = 1'b0;
    logic        reset_n, rd_start_i, busy_o, req_o, atomic_o, ack_i, valid_o, err_o;
    logic [31:0] count_i;
    logic [63:0] data_o, delta_o;

    int          total = 0;
    int          bad   = 0;

    logic [63:0] cnt;
    logic [31:0] upper;
    logic        trig, ack_kill;

    always #5 clk = ~clk;

    counter_read_master #(.ACK_TIMEOUT(4), .TMR_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_start_i (rd_start_i),
        .busy_o     (busy_o),
        .req_o      (req_o),
        .atomic_o   (atomic_o),
        .ack_i      (ack_i),
        .count_i    (count_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .err_o      (err_o),
        .delta_o    (delta_o)
    );

    // Counter model: request seen at an edge is acked in the following cycle.
    always @(posedge clk) begin : responder
        logic        r, a;
        logic [63:0] c;
        r = req_o;
        a = atomic_o;
        c = cnt;
        #1;
        if (trig) cnt = cnt + 64'd1;
        ack_i = r & ~ack_kill;
        if (r) begin
            if (a) begin
                count_i = c[31:0];
                upper   = c[63:32];
            end else begin
                count_i = upper;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue one read and stop in its T4 cycle.
    task automatic do_read(input logic [63:0] v);
        cnt = v;
        rd_start_i = 1'b1;
        step();
        rd_start_i = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        total++;
        if ({busy_o, req_o, atomic_o, valid_o, err_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000", {busy_o, req_o, atomic_o, valid_o, err_o});
        end
        total++;
        if (data_o !== 64'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", data_o);
        end
        total++;
        if (delta_o !== 64'h0) begin
            bad++;
            $display("FAIL reset_delta got=%h want=0", delta_o);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [4:0] e_req, e_atm, e_bsy, e_vld;
        e_req = 5'b00011;
        e_atm = 5'b00001;
        e_bsy = 5'b00111;
        e_vld = 5'b01000;
        cnt  = 64'h0000_0001_FFFF_FFFE;
        trig = 1'b0;
        rd_start_i = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            step();
            rd_start_i = 1'b0;
            total++;
            if ({req_o, atomic_o, busy_o, valid_o} !== {e_req[t-1], e_atm[t-1], e_bsy[t-1], e_vld[t-1]}) begin
                bad++;
                $display("FAIL single_T%0d req/atm/busy/vld got=%b want=%b", t,
                         {req_o, atomic_o, busy_o, valid_o}, {e_req[t-1], e_atm[t-1], e_bsy[t-1], e_vld[t-1]});
            end
            if (t == 4) begin
                total++;
                if (data_o !== 64'h0000_0001_FFFF_FFFE) begin
                    bad++;
                    $display("FAIL single_data got=%h want=00000001fffffffe", data_o);
                end
            end
        end
    endtask

    task automatic test_atomic();
        cnt  = 64'h0000_0000_FFFF_FFFF;
        trig = 1'b0;
        rd_start_i = 1'b1;
        step();
        rd_start_i = 1'b0;
        trig = 1'b1;
        step();
        step();
        step();
        trig = 1'b0;
        total++;
        if (valid_o !== 1'b1 || data_o !== 64'h0000_0000_FFFF_FFFF) begin
            bad++;
            $display("FAIL atomic_snapshot got=%h vld=%b want=00000000ffffffff vld=1", data_o, valid_o);
        end
    endtask

    task automatic test_held();
        logic [11:0] e_req, e_vld;
        e_req = 12'b0000_0011_0011;
        e_vld = 12'b0000_1000_1000;
        cnt = 64'h0000_1234_5678_9ABC;
        rd_start_i = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t == 5) rd_start_i = 1'b0;
            total++;
            if ({req_o, valid_o} !== {e_req[t-1], e_vld[t-1]}) begin
                bad++;
                $display("FAIL held_T%0d req/vld got=%b want=%b", t, {req_o, valid_o}, {e_req[t-1], e_vld[t-1]});
            end
            if (t == 8) begin
                total++;
                if (data_o !== 64'h0000_1234_5678_9ABC) begin
                    bad++;
                    $display("FAIL held_data got=%h want=0000123456789abc", data_o);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e_vld, e_bsy;
        e_vld = 12'b0000_1000_1000;
        e_bsy = 12'b0000_0111_0111;
        cnt = 64'h0000_5555_0000_7777;
        rd_start_i = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            step();
            rd_start_i = (t == 1 || t == 3);
            total++;
            if ({busy_o, valid_o} !== {e_bsy[t-1], e_vld[t-1]}) begin
                bad++;
                $display("FAIL pending_T%0d busy/vld got=%b want=%b", t, {busy_o, valid_o}, {e_bsy[t-1], e_vld[t-1]});
            end
        end
        rd_start_i = 1'b0;
    endtask

    task automatic test_timeout();
        logic [63:0] d_prev;
        d_prev = 64'h0000_5555_0000_7777;
        cnt = 64'hAAAA_0000_BBBB_0000;
        rd_start_i = 1'b1;
        step();
        rd_start_i = 1'b0;
        step();
        ack_kill = 1'b1;
        for (int t = 3; t <= 8; t++) begin
            step();
            total++;
            if ({busy_o, err_o, valid_o} !== {(t <= 6), (t == 7), 1'b0}) begin
                bad++;
                $display("FAIL timeout_T%0d busy/err/vld got=%b want=%b", t,
                         {busy_o, err_o, valid_o}, {(t <= 6), (t == 7), 1'b0});
            end
        end
        ack_kill = 1'b0;
        total++;
        if (data_o !== d_prev) begin
            bad++;
            $display("FAIL timeout_data_kept got=%h want=%h", data_o, d_prev);
        end
        do_read(64'hAAAA_0000_BBBB_0000);
        total++;
        if (valid_o !== 1'b1 || err_o !== 1'b0 || data_o !== 64'hAAAA_0000_BBBB_0000) begin
            bad++;
            $display("FAIL timeout_recover got=%h vld=%b err=%b want=aaaa0000bbbb0000 vld=1 err=0", data_o, valid_o, err_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [63:0] e_delta;
        cnt = 64'h1111_2222_3333_4444;
        rd_start_i = 1'b1;
        step();
        rd_start_i = 1'b0;
        step();
        total++;
        if ({req_o, atomic_o} !== 2'b10) begin
            bad++;
            $display("FAIL midrst_in_req_hi got=%b want=10", {req_o, atomic_o});
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({req_o, busy_o, atomic_o, valid_o, err_o} !== 5'b0 || data_o !== 64'h0 || delta_o !== 64'h0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b data=%h delta=%h want=00000 0 0",
                     {req_o, busy_o, atomic_o, valid_o, err_o}, data_o, delta_o);
        end
        step();
        reset_n = 1'b1;
        step();
        do_read(64'h0000_0042_0000_0099);
`ifdef COUNTER_READ_DELTA_EN
        e_delta = 64'h0000_0042_0000_0099;
`else
        e_delta = 64'h0;
`endif
        total++;
        if (valid_o !== 1'b1 || data_o !== 64'h0000_0042_0000_0099) begin
            bad++;
            $display("FAIL midrst_clean_read got=%h vld=%b want=0000004200000099 vld=1", data_o, valid_o);
        end
        total++;
        if (delta_o !== e_delta) begin
            bad++;
            $display("FAIL midrst_first_delta got=%h want=%h", delta_o, e_delta);
        end
        step();
    endtask

    task automatic test_delta();
        logic [63:0] e1, e2;
`ifdef COUNTER_READ_DELTA_EN
        e1 = 64'hFFFF_FFBE_FFFF_FF57;
        e2 = 64'h0000_0000_0000_0020;
`else
        e1 = 64'h0;
        e2 = 64'h0;
`endif
        do_read(64'h0000_0000_FFFF_FFF0);
        total++;
        if (delta_o !== e1) begin
            bad++;
            $display("FAIL delta_wrap got=%h want=%h", delta_o, e1);
        end
        step();
        do_read(64'h0000_0001_0000_0010);
        total++;
        if (data_o !== 64'h0000_0001_0000_0010 || delta_o !== e2) begin
            bad++;
            $display("FAIL delta_small got data=%h delta=%h want data=0000000100000010 delta=%h", data_o, delta_o, e2);
        end
        step();
    endtask

    initial begin
        reset_n    = 1'b0;
        rd_start_i = 1'b0;
        ack_i      = 1'b0;
        count_i    = 32'h0;
        cnt        = 64'h0;
        upper      = 32'h0;
        trig       = 1'b0;
        ack_kill   = 1'b0;
        test_reset();
        test_single();
        step();
        test_atomic();
        step();
        test_held();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_delta();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
